// File: rtl/bus_pkg.sv
// Shared definitions for the round-robin / fixed-priority bus arbiter.
//   bus_state_t          : arbiter FSM encoding (also exported as a debug port)
//   PRIO_ROUND_ROBIN     : PRIORITY_MODE value for rotating priority
//   PRIO_FIXED           : PRIORITY_MODE value for fixed priority (index 0 highest)
//   DEFAULT_TIMEOUT_LEN  : default grant-timeout counter width in bits
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } bus_state_t;

  localparam int PRIO_ROUND_ROBIN    = 0;
  localparam int PRIO_FIXED          = 1;
  localparam int DEFAULT_TIMEOUT_LEN = 6;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational winner selection.
//   request : per-master request vector
//   start   : index searched first in round-robin mode
//   mode    : 0 = rotate from start, 1 = fixed priority (index 0 first)
//   winner  : index of the selected master (0 when none)
//   found   : high when any request bit is set
module rr_priority_picker #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_WIDTH    = 2
) (
  input  logic [NUM_MASTERS-1:0] request,
  input  logic [ID_WIDTH-1:0]    start,
  input  logic                   mode,
  output logic [ID_WIDTH-1:0]    winner,
  output logic                   found
);

  int base;
  int idx;

  // Offsets are scanned from the far end toward offset 0 so the last
  // assignment made belongs to the requester closest to the start index.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    base   = mode ? 0 : int'(start);
    idx    = 0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      idx = base + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (j == idx && request[j]) begin
          winner = ID_WIDTH'(j);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Shared-bus arbiter with round-robin or fixed priority and a grant timeout.
//   clk, rst        : system clock, synchronous active-high reset
//   m_request       : per-master level request
//   b_bus_utilizing : resolved bus-in-use line
//   slv_bsy         : resolved slave-busy line, blocks new grants
//   m_grant         : registered one-hot grant
//   grant_valid     : high whenever any m_grant bit is high
//   grant_id        : index of granted master, 0 when no grant
//   timeout_err     : one-cycle pulse when a grant is revoked by timeout
//   state_dbg       : current FSM state
//
// Handshake: a master owns the bus from the cycle m_grant shows its bit
// until m_grant drops; it signals use by raising b_bus_utilizing, and the
// grant is then held until b_bus_utilizing falls. Between two grants the
// bus always sees at least two cycles with m_grant all-zero.
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS   = 4,
  parameter int TIMEOUT_LEN   = DEFAULT_TIMEOUT_LEN,
  parameter int PRIORITY_MODE = PRIO_ROUND_ROBIN,
  parameter int ID_WIDTH      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] m_request,
  input  logic                   b_bus_utilizing,
  input  logic                   slv_bsy,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic                   grant_valid,
  output logic [ID_WIDTH-1:0]    grant_id,
  output logic                   timeout_err,
  output bus_state_t             state_dbg
);

  localparam logic               MODE_FIXED = (PRIORITY_MODE == PRIO_FIXED);
  localparam logic [ID_WIDTH-1:0] LAST_IDX  = ID_WIDTH'(NUM_MASTERS - 1);

  bus_state_t               state, state_next;
  logic [TIMEOUT_LEN-1:0]   cnt, cnt_next;
  logic [ID_WIDTH-1:0]      last_granted, last_next;
  // Blocks arbitration for one IDLE cycle after reset and after a grant
  // that ended straight into IDLE, keeping the two-cycle grant gap.
  logic                     hold_off, hold_next;
  logic [NUM_MASTERS-1:0]   grant_next;
  logic                     valid_next;
  logic [ID_WIDTH-1:0]      id_next;
  logic                     terr_next;

  logic [ID_WIDTH-1:0]      start_idx;
  logic [ID_WIDTH-1:0]      winner;
  logic                     found;
  logic                     granted_req;

  assign start_idx   = (last_granted == LAST_IDX) ? '0 : last_granted + 1'b1;
  assign granted_req = |(m_request & m_grant);
  assign state_dbg   = state;

  rr_priority_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .ID_WIDTH    (ID_WIDTH)
  ) u_picker (
    .request (m_request),
    .start   (start_idx),
    .mode    (MODE_FIXED),
    .winner  (winner),
    .found   (found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      last_granted <= LAST_IDX;
      hold_off     <= 1'b1;
      m_grant      <= '0;
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      last_granted <= last_next;
      hold_off     <= hold_next;
      m_grant      <= grant_next;
      grant_valid  <= valid_next;
      grant_id     <= id_next;
      timeout_err  <= terr_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    last_next  = last_granted;
    hold_next  = hold_off;
    grant_next = m_grant;
    valid_next = grant_valid;
    id_next    = grant_id;
    terr_next  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (hold_off) begin
          hold_next = 1'b0;
        end else if (found && !slv_bsy) begin
          for (int i = 0; i < NUM_MASTERS; i++) begin
            grant_next[i] = (winner == ID_WIDTH'(i));
          end
          valid_next = 1'b1;
          id_next    = winner;
          last_next  = winner;
          cnt_next   = '0;
          state_next = ST_GRANT;
        end
      end

      ST_GRANT: begin
        cnt_next = cnt + 1'b1;
        // Bus use is checked first so it wins over a coincident timeout.
        if (b_bus_utilizing) begin
          state_next = ST_BUSY;
        end else if (!granted_req) begin
          grant_next = '0;
          valid_next = 1'b0;
          id_next    = '0;
          hold_next  = 1'b1;
          state_next = ST_IDLE;
        end else if (cnt == '1) begin
          grant_next = '0;
          valid_next = 1'b0;
          id_next    = '0;
          terr_next  = 1'b1;
          state_next = ST_RELEASE;
        end
      end

      ST_BUSY: begin
        if (!b_bus_utilizing) begin
          grant_next = '0;
          valid_next = 1'b0;
          id_next    = '0;
          state_next = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        state_next = ST_IDLE;
      end

      default: begin
        grant_next = '0;
        valid_next = 1'b0;
        id_next    = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
